// File: rtl/systolic_column_accumulator.sv
// Accumulates a systolic column's bottom-row partial sums across K tiles, then saturates and queues results.
// Optional saturation counter enabled with `define SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN.
module systolic_column_accumulator #(
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int PARTIAL_SUM_WIDTH = 17,
  parameter int NUM_ROWS          = 4,
  parameter int TILE_COUNT_WIDTH  = 8,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                clk_in,
  input  logic                                reset_n_in,
  input  logic                                start_in,
  input  logic [TILE_COUNT_WIDTH-1:0]         num_tiles_in,
  input  logic                                partial_sum_valid_in,
  input  logic signed [PARTIAL_SUM_WIDTH-1:0] partial_sum_in,
  output logic                                partial_sum_ready_out,
  output logic                                result_valid_out,
  output logic signed [FIXED_POINT_WIDTH-1:0] result_out,
  input  logic                                result_ready_in,
  output logic                                busy_out,
  output logic                                done_out
`ifdef SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN
  ,
  output logic [15:0]                         saturation_count_out
`endif
);

  localparam int ACC_WIDTH = PARTIAL_SUM_WIDTH + TILE_COUNT_WIDTH;
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  localparam logic [ROW_W-1:0]            LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]            FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TILE_COUNT_WIDTH-1:0] TILE_ONE  = TILE_COUNT_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-FIXED_POINT_WIDTH+1){1'b0}}, {(FIXED_POINT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-FIXED_POINT_WIDTH+1){1'b1}}, {(FIXED_POINT_WIDTH-1){1'b0}}};

  logic [0:0]                        r_state;
  logic [TILE_COUNT_WIDTH-1:0]       r_num_tiles;
  logic [TILE_COUNT_WIDTH-1:0]       r_tile_idx;
  logic [ROW_W-1:0]                  r_row_idx;
  logic signed [ACC_WIDTH-1:0]       r_acc      [NUM_ROWS];
  logic signed [FIXED_POINT_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                  r_wr_ptr;
  logic [PTR_W-1:0]                  r_rd_ptr;
  logic [CNT_W-1:0]                  r_fifo_count;

  logic                              w_start_ok;
  logic                              w_last_tile;
  logic                              w_last_row;
  logic                              w_accept;
  logic                              w_push;
  logic                              w_pop;
  logic signed [ACC_WIDTH-1:0]       w_ps_ext;
  logic signed [ACC_WIDTH-1:0]       w_acc_next;
  logic signed [FIXED_POINT_WIDTH-1:0] w_sat;
  logic                              w_clamped;

  assign w_start_ok  = (r_state == S_IDLE) && start_in && (num_tiles_in != '0);
  assign w_last_tile = (r_tile_idx == r_num_tiles - TILE_ONE);
  assign w_last_row  = (r_row_idx == LAST_ROW);

  // Ready depends only on registered FIFO occupancy, so a same-cycle pop never frees a slot.
  assign partial_sum_ready_out = (r_state == S_ACCUM) && (!w_last_tile || (r_fifo_count < FIFO_FULL));
  assign w_accept = partial_sum_valid_in && partial_sum_ready_out;
  assign w_push   = w_accept && w_last_tile;
  assign w_pop    = result_valid_out && result_ready_in;

  assign busy_out         = (r_state == S_ACCUM);
  assign done_out         = w_push && w_last_row;
  assign result_valid_out = (r_fifo_count != '0);
  assign result_out       = r_fifo_mem[r_rd_ptr];

  assign w_ps_ext   = {{TILE_COUNT_WIDTH{partial_sum_in[PARTIAL_SUM_WIDTH-1]}}, partial_sum_in};
  assign w_acc_next = (r_tile_idx == '0) ? w_ps_ext : r_acc[r_row_idx] + w_ps_ext;

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    w_sat     = w_acc_next[FIXED_POINT_WIDTH-1:0];
    w_clamped = 1'b0;
    if (w_acc_next > SAT_MAX) begin
      w_sat     = SAT_MAX[FIXED_POINT_WIDTH-1:0];
      w_clamped = 1'b1;
    end else if (w_acc_next < SAT_MIN) begin
      w_sat     = SAT_MIN[FIXED_POINT_WIDTH-1:0];
      w_clamped = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= S_IDLE;
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_row_idx   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_start_ok) begin
        r_state     <= S_ACCUM;
        r_num_tiles <= num_tiles_in;
        r_tile_idx  <= '0;
        r_row_idx   <= '0;
      end
    end else if (w_accept) begin
      if (w_last_row) begin
        r_row_idx  <= '0;
        r_tile_idx <= r_tile_idx + TILE_ONE;
        if (w_last_tile) r_state <= S_IDLE;
      end else begin
        r_row_idx <= r_row_idx + ROW_W'(1);
      end
    end
  end

  // NOTE: accumulator bank and FIFO storage are reset so result_out reads 0 out of reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_ROWS; i++) r_acc[i] <= '0;
    end else if (w_accept) begin
      r_acc[r_row_idx] <= w_acc_next;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= w_sat;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + CNT_W'(1);
      else if (w_pop && !w_push) r_fifo_count <= r_fifo_count - CNT_W'(1);
    end
  end

`ifdef SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sat_count <= '0;
    end else if (w_start_ok) begin
      r_sat_count <= '0;
    end else if (w_push && w_clamped && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign saturation_count_out = r_sat_count;
`endif

endmodule

// File: tb/tb_systolic_column_accumulator.sv
// Scoreboard bench for systolic_column_accumulator: directed jobs push expected results, a monitor pops and compares.
module tb_systolic_column_accumulator;

  localparam int FPW = 16;
  localparam int PSW = 17;
  localparam int TCW = 8;

  logic                  clk_in;
  logic                  reset_n_in;
  logic                  start_in;
  logic [TCW-1:0]        num_tiles_in;
  logic                  partial_sum_valid_in;
  logic signed [PSW-1:0] partial_sum_in;
  logic                  partial_sum_ready_out;
  logic                  result_valid_out;
  logic signed [FPW-1:0] result_out;
  logic                  result_ready_in;
  logic                  busy_out;
  logic                  done_out;
`ifdef SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN
  logic [15:0]           saturation_count_out;
`endif

  systolic_column_accumulator #(
    .FIXED_POINT_WIDTH(FPW),
    .PARTIAL_SUM_WIDTH(PSW),
    .NUM_ROWS(4),
    .TILE_COUNT_WIDTH(TCW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_in               (clk_in),
    .reset_n_in           (reset_n_in),
    .start_in             (start_in),
    .num_tiles_in         (num_tiles_in),
    .partial_sum_valid_in (partial_sum_valid_in),
    .partial_sum_in       (partial_sum_in),
    .partial_sum_ready_out(partial_sum_ready_out),
    .result_valid_out     (result_valid_out),
    .result_out           (result_out),
    .result_ready_in      (result_ready_in),
    .busy_out             (busy_out),
    .done_out             (done_out)
`ifdef SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN
    ,
    .saturation_count_out (saturation_count_out)
`endif
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_q[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each negedge with valid & ready is exactly one pop at the following posedge.
  always @(negedge clk_in) begin
    if (reset_n_in && result_valid_out && result_ready_in) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_result: got %0d, expected no result", result_out);
      end else begin
        check("result", int'(result_out), exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input int nt);
    @(posedge clk_in);
    #1;
    start_in     = 1'b1;
    num_tiles_in = TCW'(nt);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  // Present one partial sum and hold it until accepted; returns done_out seen at the accept.
  task automatic send(input int v, output int done_seen);
    int n;
    n = 0;
    done_seen = 0;
    partial_sum_valid_in = 1'b1;
    partial_sum_in       = PSW'(v);
    @(negedge clk_in);
    while (!partial_sum_ready_out && n < 200) begin
      n++;
      @(negedge clk_in);
    end
    if (!partial_sum_ready_out) begin
      check("send_timeout", 0, 1);
    end else begin
      done_seen = int'(done_out);
      @(posedge clk_in);
    end
    #1;
    partial_sum_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk_in);
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d;
    int v1[4] = '{5, -7, 0, 100};
    int v3[4] = '{10, 20, 30, 40};
    int s0[4] = '{30000, -30000, 0, 0};
    int sx[4] = '{32767, -32768, 0, 0};

    reset_n_in           = 1'b0;
    start_in             = 1'b0;
    num_tiles_in         = '0;
    partial_sum_valid_in = 1'b0;
    partial_sum_in       = '0;
    result_ready_in      = 1'b1;

    #12;
    check("rst_busy", int'(busy_out), 0);
    check("rst_ready", int'(partial_sum_ready_out), 0);
    check("rst_valid", int'(result_valid_out), 0);
    check("rst_result", int'(result_out), 0);
    check("rst_done", int'(done_out), 0);
    #5 reset_n_in = 1'b1;

    // Reset mid-job after three accepts
    do_start(2);
    @(negedge clk_in);
    check("t1_busy", int'(busy_out), 1);
    for (int i = 0; i < 3; i++) send(9, d);
    #2 reset_n_in = 1'b0;
    #1;
    check("t1_rst_busy", int'(busy_out), 0);
    check("t1_rst_valid", int'(result_valid_out), 0);
    check("t1_rst_ready", int'(partial_sum_ready_out), 0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i + 1);
      send(i + 1, d);
    end
    wait_drain();

    // Single tile, one-cycle latency and done pulse
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(v1[i]);
      send(v1[i], d);
      check("t2_latency_valid", int'(result_valid_out), 1);
      check("t2_done", d, (i == 3) ? 1 : 0);
    end
    @(negedge clk_in);
    check("t2_idle_busy", int'(busy_out), 0);
    wait_drain();

    // Three tiles
    do_start(3);
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 4; r++) begin
        if (t == 2) exp_q.push_back(3 * v3[r]);
        send(v3[r], d);
        check("t3_done", d, (t == 2 && r == 3) ? 1 : 0);
        if (t < 2) check("t3_no_early_valid", int'(result_valid_out), 0);
      end
    end
    wait_drain();

    // Saturation
    do_start(2);
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 4; r++) begin
        if (t == 1) exp_q.push_back(sx[r]);
        send(s0[r], d);
      end
    end
    wait_drain();
`ifdef SYSTOLIC_ACCUMULATOR_SAT_COUNT_EN
    check("t4_sat_count", int'(saturation_count_out), 2);
`endif

    // Backpressure
    result_ready_in = 1'b0;
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(11 + i);
      send(11 + i, d);
    end
    do_start(1);
    partial_sum_valid_in = 1'b1;
    partial_sum_in       = PSW'(21);
    exp_q.push_back(21);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("t5_full_hold", int'(partial_sum_ready_out), 0);
    end
    @(posedge clk_in);
    #1 result_ready_in = 1'b1;
    @(negedge clk_in);
    check("t5_no_comb_path", int'(partial_sum_ready_out), 0);
    @(posedge clk_in);
    #1 result_ready_in = 1'b0;
    @(negedge clk_in);
    check("t5_ready_after_pop", int'(partial_sum_ready_out), 1);
    @(posedge clk_in);
    #1 partial_sum_valid_in = 1'b0;
    result_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(22 + i);
      send(22 + i, d);
    end
    check("t5_done", d, 1);
    wait_drain();

    // Ignored starts
    do_start(0);
    @(negedge clk_in);
    check("t6_zero_start_idle", int'(busy_out), 0);
    do_start(1);
    exp_q.push_back(7);
    send(7, d);
    do_start(5);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8 + i);
      send(8 + i, d);
    end
    check("t6_done", d, 1);
    @(negedge clk_in);
    check("t6_idle_after", int'(busy_out), 0);
    wait_drain();
    repeat (3) @(negedge clk_in);
    check("final_fifo_empty", int'(result_valid_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
